match_scheduler: RTL and testbench

MATCH_SCHEDULER -- requirements
Module: match_scheduler

---
 rtl/match_scheduler.sv | 143 ++++++++++++++
 tb/tb_match_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_scheduler.sv
// Distributes candidate string offsets across NUM_SLAVE matcher engines and
// reports the lowest offset at which any engine found the pattern.
module match_scheduler #(
  parameter int NUM_SLAVE = 4,
  parameter int STR_ADD   = 5,
  parameter int PAT_ADD   = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid,
  input  logic [STR_ADD-1:0]             str_last_idx,
  input  logic [PAT_ADD-1:0]             pat_last_idx,
  output logic [NUM_SLAVE-1:0]           slv_start,
  output logic [NUM_SLAVE*STR_ADD-1:0]   slv_offset,
  input  logic [NUM_SLAVE-1:0]           slv_done,
  input  logic [NUM_SLAVE-1:0]           slv_hit,
  output logic                           busy,
  output logic                           finish,
  output logic                           match,
  output logic [STR_ADD-1:0]             match_idx
);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, REPORT} state_t;

  state_t               state;
  logic [STR_ADD-1:0]   last_off;
  logic [STR_ADD-1:0]   next_off;
  logic                 exhausted;
  logic [NUM_SLAVE-1:0] slv_busy;
  logic                 hit_found;
  logic [STR_ADD-1:0]   best;

  logic [STR_ADD-1:0]   pat_ext;
  logic [NUM_SLAVE-1:0] done_v;
  logic [NUM_SLAVE-1:0] assign_mask;
  logic [NUM_SLAVE*STR_ADD-1:0] new_off;
  logic [STR_ADD-1:0]   cur;
  logic                 exhausted_c;
  logic                 hit_now;
  logic                 cand_valid;
  logic [STR_ADD-1:0]   cand;
  logic [STR_ADD-1:0]   done_off;
  logic                 stop;

  assign pat_ext = {{(STR_ADD-PAT_ADD){1'b0}}, pat_last_idx};
  assign done_v  = slv_done & slv_busy;
  assign busy    = (state != IDLE);

  // Lowest offset among this cycle's hits, merged with the recorded best.
  always_comb begin
    hit_now    = 1'b0;
    cand       = best;
    cand_valid = hit_found;
    done_off   = '0;
    for (int i = 0; i < NUM_SLAVE; i++) begin
      if (done_v[i] && slv_hit[i]) begin
        hit_now  = 1'b1;
        done_off = slv_offset[i*STR_ADD +: STR_ADD];
        if (!cand_valid || done_off < cand) begin
          cand       = done_off;
          cand_valid = 1'b1;
        end
      end
    end
  end

  assign stop = hit_found | hit_now;

  // Hand ascending offsets to free slaves, lowest index first. The exhausted
  // flag marks last_off as issued so the counter never needs to wrap.
  always_comb begin
    assign_mask = '0;
    new_off     = slv_offset;
    cur         = next_off;
    exhausted_c = exhausted;
    if (state == DISPATCH && !stop) begin
      for (int i = 0; i < NUM_SLAVE; i++) begin
        if (!slv_busy[i] && !exhausted_c) begin
          assign_mask[i]                  = 1'b1;
          new_off[i*STR_ADD +: STR_ADD]   = cur;
          if (cur == last_off) exhausted_c = 1'b1;
          else                 cur         = cur + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_off   <= '0;
      next_off   <= '0;
      exhausted  <= 1'b0;
      slv_busy   <= '0;
      hit_found  <= 1'b0;
      best       <= '0;
      slv_start  <= '0;
      slv_offset <= '0;
      finish     <= 1'b0;
      match      <= 1'b0;
      match_idx  <= '0;
    end else begin
      slv_start <= assign_mask;
      finish    <= 1'b0;
      slv_busy  <= (slv_busy & ~done_v) | assign_mask;
      if (state == DISPATCH || state == DRAIN) begin
        hit_found <= cand_valid;
        best      <= cand;
      end
      case (state)
        IDLE: begin
          if (valid) begin
            last_off  <= str_last_idx - pat_ext;
            next_off  <= '0;
            exhausted <= 1'b0;
            hit_found <= 1'b0;
            best      <= '0;
            match     <= 1'b0;
            match_idx <= '0;
            state     <= (str_last_idx < pat_ext) ? REPORT : DISPATCH;
          end
        end
        DISPATCH: begin
          slv_offset <= new_off;
          next_off   <= cur;
          exhausted  <= exhausted_c;
          if (stop || exhausted_c) state <= DRAIN;
        end
        DRAIN: begin
          if (slv_busy == '0) state <= REPORT;
        end
        REPORT: begin
          finish    <= 1'b1;
          match     <= hit_found;
          match_idx <= hit_found ? best : '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_scheduler.sv
// Directed bench for match_scheduler with a latency-programmable slave model.
module tb_match_scheduler;

  localparam int NS = 4;
  localparam int SW = 5;
  localparam int PW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid;
  logic [SW-1:0]     str_last_idx;
  logic [PW-1:0]     pat_last_idx;
  logic [NS-1:0]     slv_start;
  logic [NS*SW-1:0]  slv_offset;
  logic [NS-1:0]     slv_done;
  logic [NS-1:0]     slv_hit;
  logic              busy;
  logic              finish;
  logic              match;
  logic [SW-1:0]     match_idx;

  match_scheduler #(.NUM_SLAVE(NS), .STR_ADD(SW), .PAT_ADD(PW)) dut (
    .clk(clk), .reset(reset), .valid(valid),
    .str_last_idx(str_last_idx), .pat_last_idx(pat_last_idx),
    .slv_start(slv_start), .slv_offset(slv_offset),
    .slv_done(slv_done), .slv_hit(slv_hit),
    .busy(busy), .finish(finish), .match(match), .match_idx(match_idx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  logic [31:0] hit_set;
  int lat [NS];
  int cnt [NS];
  int off [NS];

  int  issue_cnt [32];
  int  first_slave [32];
  int  n_starts, max_off, starts_after_hit;
  bit  hit_seen, fin_seen, fin_match;
  int  fin_cycle, fin_idx, vcyc;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_sb();
    for (int k = 0; k < 32; k++) begin
      issue_cnt[k]   = 0;
      first_slave[k] = -1;
    end
    n_starts = 0; max_off = -1; starts_after_hit = 0;
    hit_seen = 0; fin_seen = 0; fin_match = 0; fin_cycle = 0; fin_idx = 0;
  endtask

  // One cycle: observe DUT at the falling edge, then drive slave responses.
  task automatic step();
    bit got;
    int o;
    @(negedge clk);
    cycle++;
    got = 0;
    slv_done = '0;
    slv_hit  = '0;
    for (int i = 0; i < NS; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          slv_done[i] = 1'b1;
          slv_hit[i]  = hit_set[off[i]];
          if (hit_set[off[i]]) got = 1;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (slv_start[i]) begin
        o = int'(slv_offset[i*SW +: SW]);
        off[i] = o;
        cnt[i] = lat[i];
        issue_cnt[o]++;
        n_starts++;
        if (first_slave[o] < 0) first_slave[o] = i;
        if (o > max_off) max_off = o;
        if (hit_seen) starts_after_hit++;
      end
    end
    if (got) hit_seen = 1;
    if (finish && !fin_seen) begin
      fin_seen  = 1;
      fin_cycle = cycle;
      fin_match = match;
      fin_idx   = int'(match_idx);
    end
  endtask

  task automatic run_job(input logic [SW-1:0] s, input logic [PW-1:0] p,
                         input bit pulse_mid, input string tag);
    clear_sb();
    str_last_idx = s;
    pat_last_idx = p;
    valid = 1'b1;
    vcyc = cycle;
    step();
    valid = 1'b0;
    while (!fin_seen && (cycle - vcyc) < 200) begin
      valid = pulse_mid && (cycle == vcyc + 4);
      if (valid) begin
        str_last_idx = 5'd31;
        pat_last_idx = 3'd0;
      end
      step();
    end
    valid = 1'b0;
    check({tag, "_finish_seen"}, int'(fin_seen), 1);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; str_last_idx = '0; pat_last_idx = '0;
    slv_done = '0; slv_hit = '0; hit_set = '0;
    for (int i = 0; i < NS; i++) begin lat[i] = 2; cnt[i] = 0; off[i] = 0; end
    clear_sb();
    step(); step();
    check("rst_start", int'(slv_start), 0);
    check("rst_offset", int'(slv_offset), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_finish", int'(finish), 0);
    check("rst_match", int'(match), 0);
    check("rst_idx", int'(match_idx), 0);
    reset = 1'b0;
    step();

    // Offsets 0..7, no hits
    hit_set = '0;
    run_job(5'd9, 3'd2, 0, "nohit");
    check("nohit_starts", n_starts, 8);
    check("nohit_max", max_off, 7);
    begin
      int uniq = 0;
      for (int k = 0; k < 8; k++) if (issue_cnt[k] == 1) uniq++;
      check("nohit_unique", uniq, 8);
    end
    for (int k = 0; k < 4; k++) check("nohit_first_slave", first_slave[k], k);
    check("nohit_match", int'(fin_match), 0);
    check("nohit_idx", fin_idx, 0);

    // Single hit at 13 across the full string
    hit_set = 32'h1 << 13;
    run_job(5'd31, 3'd0, 0, "hit13");
    check("hit13_starts", n_starts, 16);
    check("hit13_max", max_off, 15);
    check("hit13_after", starts_after_hit, 0);
    check("hit13_match", int'(fin_match), 1);
    check("hit13_idx", fin_idx, 13);

    // Same-cycle hits at 5 and 6
    hit_set = (32'h1 << 5) | (32'h1 << 6);
    run_job(5'd9, 3'd2, 0, "dual");
    check("dual_match", int'(fin_match), 1);
    check("dual_idx", fin_idx, 5);

    // Late lower hit replaces an earlier higher one
    hit_set = (32'h1 << 1) | (32'h1 << 3);
    lat[0] = 1; lat[1] = 6; lat[2] = 1; lat[3] = 1;
    run_job(5'd31, 3'd0, 0, "late_low");
    check("late_low_starts", n_starts, 4);
    check("late_low_idx", fin_idx, 1);
    check("late_low_match", int'(fin_match), 1);
    for (int i = 0; i < NS; i++) lat[i] = 2;

    // Pattern longer than string
    hit_set = '1;
    run_job(5'd2, 3'd5, 0, "short");
    check("short_starts", n_starts, 0);
    check("short_latency", fin_cycle - vcyc, 2);
    check("short_match", int'(fin_match), 0);

    // valid while busy is ignored
    hit_set = '0;
    run_job(5'd9, 3'd2, 1, "revalid");
    check("revalid_starts", n_starts, 8);
    check("revalid_max", max_off, 7);
    check("revalid_match", int'(fin_match), 0);
    step();
    check("revalid_idle", int'(busy), 0);

    // Asynchronous reset mid-dispatch
    hit_set = 32'h1;
    lat[0] = 8; lat[1] = 8; lat[2] = 8; lat[3] = 1;
    clear_sb();
    str_last_idx = 5'd31; pat_last_idx = 3'd0; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    check("mid_starts", n_starts, 4);
    check("mid_busy", int'(busy), 1);
    step();
    #2 reset = 1'b1;
    #1;
    check("async_start", int'(slv_start), 0);
    check("async_offset", int'(slv_offset), 0);
    check("async_busy", int'(busy), 0);
    check("async_finish", int'(finish), 0);
    check("async_match", int'(match), 0);
    step(); step();
    reset = 1'b0;
    clear_sb();
    for (int k = 0; k < 10; k++) step();
    check("post_rst_starts", n_starts, 0);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_finish", int'(fin_seen), 0);
    for (int i = 0; i < NS; i++) lat[i] = 2;
    hit_set = '0;
    run_job(5'd9, 3'd2, 0, "clean");
    check("clean_starts", n_starts, 8);
    check("clean_match", int'(fin_match), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
